// File: rtl/adder_pkg.sv
// Shared definitions for the parallel-adder result path: sample widths and
// the accumulator handshake state encoding.
package adder_pkg;

    // Width of the adder's sum output and of a full {c_out, sum} sample.
    localparam int NIBBLE_W = 4;
    localparam int SAMPLE_W = 5;

    // ACC collects samples; HOLD presents a finished result to the consumer.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : adder_pkg

// File: rtl/acc_add_sat.sv
// Combinational accumulator update: adds one zero-extended 5-bit sample to
// the running total and reports the carry out of the top accumulator bit.
// Build option: define ACC_SAT_EN to clamp the total to all-ones on overflow
// instead of wrapping.
module acc_add_sat
    import adder_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [ACC_W-1:0]    sum,
    output logic                carry
);

    logic [ACC_W:0] wide;

    // One extra bit captures the carry out of bit ACC_W-1.
    assign wide  = {1'b0, acc} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample};
    assign carry = wide[ACC_W];

`ifdef ACC_SAT_EN
    // Clamp on overflow; once at all-ones every later sample either carries
    // again or adds zero, so the total stays pinned.
    assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    // Plain modulo-2^ACC_W wrap.
    assign sum = wide[ACC_W-1:0];
`endif

endmodule : acc_add_sat

// File: rtl/adder_result_accumulator.sv
// Accumulates NUM_SAMPLES adder results ({c_out, sum}) and presents the total
// plus a sticky overflow flag on a valid/ready port, holding it until taken.
// Optional build macro: ACC_SAT_EN (saturating accumulation, see acc_add_sat).
module adder_result_accumulator
    import adder_pkg::*;
#(
    parameter int ACC_W       = 12,
    parameter int NUM_SAMPLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_sum,
    input  logic                in_c_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_acc,
    output logic                out_ovf
);

    // Counter must reach NUM_SAMPLES itself while the result is held.
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ovf, ovf_next;
    logic [ACC_W-1:0]  out_acc_q, out_acc_next;
    logic              out_ovf_q, out_ovf_next;

    logic [SAMPLE_W-1:0] sample;
    logic [ACC_W-1:0]    add_sum;
    logic                add_carry;

    assign sample = {in_c_out, in_sum};

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_acc_add_sat (
        .acc    (acc),
        .sample (sample),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // Handshake outputs follow the state directly, so reset drives them at once.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;

    // Next-state and datapath update; clear overrides accepts and releases.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        ovf_next     = ovf;
        out_acc_next = out_acc_q;
        out_ovf_next = out_ovf_q;

        if (clear) begin
            state_next = ST_ACC;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_next = add_sum;
                        ovf_next = ovf | add_carry;
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            out_acc_next = add_sum;
                            out_ovf_next = ovf | add_carry;
                            state_next   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                        state_next = ST_ACC;
                    end
                end
                default: state_next = ST_ACC;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled only on the clock edge, so it lives inside
        // the clocked branch and rst_n stays out of the sensitivity list;
        // non-blocking assignments keep all registers updating in parallel.
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            ovf       <= ovf_next;
            out_acc_q <= out_acc_next;
            out_ovf_q <= out_ovf_next;
        end
    end

endmodule : adder_result_accumulator

// File: tb/tb_adder_result_accumulator.sv
// Directed bench: a default instance (ACC_W=12) and a narrow instance
// (ACC_W=7) share stimulus; results are compared against hand-computed values.
module tb_adder_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_sum;
    logic        in_c_out;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf;
    logic [11:0] out_acc;
    logic        n_in_ready, n_out_valid, n_out_ovf;
    logic [6:0]  n_out_acc;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ACC_SAT_EN
    localparam int NARROW_31X8 = 127;
`else
    localparam int NARROW_31X8 = 120;
`endif

    always #5 clk = ~clk;

    adder_result_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_c_out  (in_c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    adder_result_accumulator #(.ACC_W(7), .NUM_SAMPLES(8)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .in_sum    (in_sum),
        .in_c_out  (in_c_out),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .out_acc   (n_out_acc),
        .out_ovf   (n_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one clock; called at a negedge, returns at the next.
    task automatic push(input logic [4:0] v);
        in_valid = 1'b1;
        {in_c_out, in_sum} = v;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        {in_c_out, in_sum} = 5'd0;
    endtask

    // One-cycle out_ready pulse to release a held result.
    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        int budget;

        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc",   out_acc,   0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_in_ready",  in_ready,  1);
        rst_n = 1'b1;
        @(negedge clk);

        // Eight back-to-back samples of 31.
        for (int i = 0; i < 7; i++) push(5'd31);
        check("t1_not_yet_valid", out_valid, 0);
        push(5'd31);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_acc",   out_acc,   248);
        check("t1_out_ovf",   out_ovf,   0);
        check("t1_n_out_acc", n_out_acc, NARROW_31X8);
        check("t1_n_out_ovf", n_out_ovf, 1);

        // Back-pressure: in_valid stays high, result must not move.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_acc",   out_acc,   248);
            check("hold_out_ovf",   out_ovf,   0);
            check("hold_in_ready",  in_ready,  0);
        end
        idle();
        release_result();
        check("rel_in_ready",  in_ready,  1);
        check("rel_out_valid", out_valid, 0);

        // Eight samples of 2 with random bubbles; must start from zero.
        accepted = 0;
        budget   = 0;
        while (accepted < 8 && budget < 200) begin
            if ($urandom_range(0, 1) == 1) begin
                push(5'd2);
                accepted++;
            end else begin
                idle();
                @(negedge clk);
            end
            budget++;
        end
        idle();
        check("bub_budget",    accepted,    8);
        check("bub_out_valid", out_valid,   1);
        check("bub_out_acc",   out_acc,     16);
        check("bub_out_ovf",   out_ovf,     0);
        check("bub_n_out_acc", n_out_acc,   16);
        check("bub_n_out_ovf", n_out_ovf,   0);
        release_result();

        // Three samples of 10, clear with a concurrent sample, then eight 1s.
        for (int i = 0; i < 3; i++) push(5'd10);
        clear = 1'b1;
        push(5'd10);
        clear = 1'b0;
        check("clr_in_ready",  in_ready,  1);
        check("clr_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) push(5'd1);
        idle();
        check("clr_out_valid2", out_valid, 1);
        check("clr_out_acc",    out_acc,   8);
        check("clr_out_ovf",    out_ovf,   0);

        // Clear discards a held result even with out_ready asserted.
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; out_ready = 1'b0;
        check("clr_hold_out_valid", out_valid, 0);
        check("clr_hold_in_ready",  in_ready,  1);

        // Reach HOLD with 8x3, then reset for one cycle.
        for (int i = 0; i < 8; i++) push(5'd3);
        idle();
        check("pre_rst_out_acc", out_acc, 24);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_acc",   out_acc,   0);
        check("mid_rst_out_ovf",   out_ovf,   0);
        check("mid_rst_in_ready",  in_ready,  1);
        for (int i = 0; i < 8; i++) push(5'd1);
        idle();
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_out_acc",   out_acc,   8);
        check("post_rst_n_out_acc", n_out_acc, 8);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_adder_result_accumulator
